// File: rtl/register_file_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_unit_pkg
// Description : Shared opcodes, FSM states, register/pair indices and the
//               pair index helpers for register_file_unit.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package register_unit_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_LD      = 2'd1,
        OP_PAIR_LD = 2'd2,
        OP_INC     = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int REG_A  = 0;
    localparam int REG_B  = 1;
    localparam int REG_C  = 2;
    localparam int REG_D  = 3;
    localparam int REG_M1 = 4;
    localparam int REG_M2 = 5;
    localparam int REG_X  = 6;
    localparam int REG_Y  = 7;

    localparam int PAIR_M  = 0;
    localparam int PAIR_XY = 1;

    // Pairs occupy the top 2*pair_count registers, hi byte at the even slot.
    function automatic int pair_hi_idx(input int num_regs, input int pair_count, input int p);
        return num_regs - 2 * pair_count + 2 * p;
    endfunction

    function automatic int pair_lo_idx(input int num_regs, input int pair_count, input int p);
        return pair_hi_idx(num_regs, pair_count, p) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_unit_pair_incrementer.sv
`default_nettype none
// ============================================================================
// Module      : pair_incrementer
// Description : Combinational word incrementer, wraps to zero, no carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module pair_incrementer #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_result
);

    assign o_result = i_value + WIDTH'(1);

endmodule
`default_nettype wire

// File: rtl/register_file_unit.sv
`default_nettype none
// ============================================================================
// Module      : register_file_unit
// Description : Byte register bank with 16-bit pairs, pair load/increment and
//               a busy/done write handshake. Define RELAY_SETTLE_EN to model
//               multi-cycle relay settle; otherwise writes commit on accept.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module register_file_unit
    import register_unit_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int NUM_REGS      = 8,
    parameter int PAIR_COUNT    = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 ld_req,
    input  logic [$clog2(NUM_REGS)-1:0]                          ld_sel,
    input  logic [DATA_W-1:0]                                    ld_data,
    input  logic                                                 pair_ld_req,
    input  logic                                                 inc_req,
    input  logic [((PAIR_COUNT > 1) ? $clog2(PAIR_COUNT) : 1)-1:0] pair_sel,
    input  logic [2*DATA_W-1:0]                                  pair_data,
    output logic                                                 busy,
    output logic                                                 done,
    input  logic [$clog2(NUM_REGS)-1:0]                          rd_sel,
    output logic [DATA_W-1:0]                                    rd_data,
    output logic [2*DATA_W-1:0]                                  pair_rd_data,
    output logic [DATA_W-1:0]                                    alu_b,
    output logic [DATA_W-1:0]                                    alu_c
);

    localparam int c_sel_w  = $clog2(NUM_REGS);
    localparam int c_psel_w = (PAIR_COUNT > 1) ? $clog2(PAIR_COUNT) : 1;
    localparam int c_word_w = 2 * DATA_W;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    op_e                 w_req_op;
    logic [c_sel_w-1:0]  w_req_sel;
    logic [c_psel_w-1:0] w_req_psel;
    logic [c_word_w-1:0] w_req_data;

    op_e                 w_cmd_op;
    logic [c_sel_w-1:0]  w_cmd_sel;
    logic [c_psel_w-1:0] w_cmd_psel;
    logic [c_word_w-1:0] w_cmd_data;
    logic                w_commit;

    logic [c_sel_w-1:0]  w_cmd_hi;
    logic [c_sel_w-1:0]  w_cmd_lo;
    logic                w_cmd_sel_ok;
    logic                w_cmd_pair_ok;
    logic [c_word_w-1:0] w_inc_src;
    logic [c_word_w-1:0] w_inc_res;

    logic [c_sel_w-1:0]  w_rd_hi;
    logic [c_sel_w-1:0]  w_rd_lo;
    logic                w_rd_sel_ok;
    logic                w_rd_pair_ok;

    // Fixed priority; losing requests are simply dropped.
    always_comb begin
        w_req_op   = OP_NONE;
        w_req_sel  = ld_sel;
        w_req_psel = pair_sel;
        w_req_data = '0;
        if (pair_ld_req) begin
            w_req_op   = OP_PAIR_LD;
            w_req_data = pair_data;
        end else if (inc_req) begin
            w_req_op   = OP_INC;
        end else if (ld_req) begin
            w_req_op   = OP_LD;
            w_req_data = {{DATA_W{1'b0}}, ld_data};
        end
    end

`ifdef RELAY_SETTLE_EN
    localparam int c_settle = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int c_cnt_w  = $clog2(c_settle + 1);

    state_e              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_busy;
    logic                r_done;
    op_e                 r_op;
    logic [c_sel_w-1:0]  r_sel;
    logic [c_psel_w-1:0] r_psel;
    logic [c_word_w-1:0] r_data;

    assign w_cmd_op   = r_op;
    assign w_cmd_sel  = r_sel;
    assign w_cmd_psel = r_psel;
    assign w_cmd_data = r_data;
    assign w_commit   = (r_state == SETTLE) && (r_cnt == c_cnt_w'(c_settle));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= OP_NONE;
            r_sel   <= '0;
            r_psel  <= '0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_op != OP_NONE) begin
                        r_op    <= w_req_op;
                        r_sel   <= w_req_sel;
                        r_psel  <= w_req_psel;
                        r_data  <= w_req_data;
                        r_cnt   <= c_cnt_w'(1);
                        r_busy  <= 1'b1;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_commit) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
`else
    logic r_done;

    assign w_cmd_op   = w_req_op;
    assign w_cmd_sel  = w_req_sel;
    assign w_cmd_psel = w_req_psel;
    assign w_cmd_data = w_req_data;
    assign w_commit   = (w_req_op != OP_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
        end
    end

    assign busy = 1'b0;
    assign done = r_done;
`endif

    assign w_cmd_sel_ok  = int'(w_cmd_sel) < NUM_REGS;
    assign w_cmd_pair_ok = int'(w_cmd_psel) < PAIR_COUNT;
    assign w_cmd_hi      = c_sel_w'(pair_hi_idx(NUM_REGS, PAIR_COUNT, int'(w_cmd_psel)));
    assign w_cmd_lo      = c_sel_w'(pair_lo_idx(NUM_REGS, PAIR_COUNT, int'(w_cmd_psel)));
    assign w_inc_src     = w_cmd_pair_ok ? {r_regs[w_cmd_hi], r_regs[w_cmd_lo]} : '0;

    pair_incrementer #(
        .WIDTH (c_word_w)
    ) u_pair_incrementer (
        .i_value  (w_inc_src),
        .o_result (w_inc_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            case (w_cmd_op)
                OP_LD: begin
                    if (w_cmd_sel_ok) begin
                        r_regs[w_cmd_sel] <= w_cmd_data[DATA_W-1:0];
                    end
                end
                OP_PAIR_LD: begin
                    if (w_cmd_pair_ok) begin
                        r_regs[w_cmd_hi] <= w_cmd_data[c_word_w-1:DATA_W];
                        r_regs[w_cmd_lo] <= w_cmd_data[DATA_W-1:0];
                    end
                end
                OP_INC: begin
                    if (w_cmd_pair_ok) begin
                        r_regs[w_cmd_hi] <= w_inc_res[c_word_w-1:DATA_W];
                        r_regs[w_cmd_lo] <= w_inc_res[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_rd_sel_ok  = int'(rd_sel) < NUM_REGS;
    assign w_rd_pair_ok = int'(pair_sel) < PAIR_COUNT;
    assign w_rd_hi      = c_sel_w'(pair_hi_idx(NUM_REGS, PAIR_COUNT, int'(pair_sel)));
    assign w_rd_lo      = c_sel_w'(pair_lo_idx(NUM_REGS, PAIR_COUNT, int'(pair_sel)));

    assign rd_data      = w_rd_sel_ok ? r_regs[rd_sel] : '0;
    assign pair_rd_data = w_rd_pair_ok ? {r_regs[w_rd_hi], r_regs[w_rd_lo]} : '0;
    assign alu_b        = r_regs[c_sel_w'(REG_B)];
    assign alu_c        = r_regs[c_sel_w'(REG_C)];

endmodule
`default_nettype wire

// File: tb/tb_register_file_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_unit
// Description : Self-checking bench for register_file_unit (both settings of
//               RELAY_SETTLE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_unit;

    localparam int c_op_ld  = 0;
    localparam int c_op_pld = 1;
    localparam int c_op_inc = 2;

`ifdef RELAY_SETTLE_EN
    localparam int c_exp_lat  = 2;
    localparam int c_exp_busy = 2;
`else
    localparam int c_exp_lat  = 0;
    localparam int c_exp_busy = 0;
`endif

    typedef struct {
        int          op;
        logic [2:0]  idx;
        logic [15:0] data;
        logic [2:0]  chk_sel;
        logic [7:0]  exp_byte;
        logic        chk_pair;
        logic [15:0] exp_pair;
    } vec_t;

    typedef struct {
        logic [2:0]  chk_sel;
        logic [7:0]  exp_byte;
        logic        chk_pair;
        logic [15:0] exp_pair;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req, pair_ld_req, inc_req;
    logic [2:0]  ld_sel, rd_sel;
    logic [7:0]  ld_data;
    logic [0:0]  pair_sel;
    logic [15:0] pair_data;
    logic        busy, done;
    logic [7:0]  rd_data, alu_b, alu_c;
    logic [15:0] pair_rd_data;

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];
    vec_t vecs[10];
    logic [7:0] exp_final[8];

    register_file_unit dut (
        .clk          (clk),
        .reset        (reset),
        .ld_req       (ld_req),
        .ld_sel       (ld_sel),
        .ld_data      (ld_data),
        .pair_ld_req  (pair_ld_req),
        .inc_req      (inc_req),
        .pair_sel     (pair_sel),
        .pair_data    (pair_data),
        .busy         (busy),
        .done         (done),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .pair_rd_data (pair_rd_data),
        .alu_b        (alu_b),
        .alu_c        (alu_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int op, input logic [2:0] idx, input logic [15:0] data,
                                input logic [2:0] cs, input logic [7:0] eb,
                                input logic cp, input logic [15:0] ep);
        vec_t v;
        v.op = op; v.idx = idx; v.data = data;
        v.chk_sel = cs; v.exp_byte = eb; v.chk_pair = cp; v.exp_pair = ep;
        return v;
    endfunction

    // Waits (bounded) for done; returns edges seen after the accept edge and busy cycles.
    task automatic wait_done(output int lat, output int nb);
        lat = 0;
        nb  = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) nb++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int lat, nb;
        @(negedge clk);
        ld_req      = (v.op == c_op_ld);
        pair_ld_req = (v.op == c_op_pld);
        inc_req     = (v.op == c_op_inc);
        ld_sel      = v.idx;
        pair_sel    = v.idx[0];
        ld_data     = v.data[7:0];
        pair_data   = v.data;
        e.chk_sel = v.chk_sel; e.exp_byte = v.exp_byte;
        e.chk_pair = v.chk_pair; e.exp_pair = v.exp_pair;
        sbq.push_back(e);
        @(posedge clk); #1;
        ld_req = 1'b0; pair_ld_req = 1'b0; inc_req = 1'b0;
        wait_done(lat, nb);
        chk("latency", 32'(lat), 32'(c_exp_lat));
        chk("busy_cycles", 32'(nb), 32'(c_exp_busy));
        if (done === 1'b1 && sbq.size() > 0) begin
            e = sbq.pop_front();
            rd_sel   = e.chk_sel;
            pair_sel = e.chk_pair;
            #1;
            chk("rd_data", 32'(rd_data), 32'(e.exp_byte));
            chk("pair_rd_data", 32'(pair_rd_data), 32'(e.exp_pair));
        end else begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=%b, expected 1", done);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
        @(posedge clk); #1;
        chk("done_clear", 32'(done), 32'(0));
    endtask

    initial begin
        int lat, nb, seen;
        reset = 1'b1;
        ld_req = 1'b0; pair_ld_req = 1'b0; inc_req = 1'b0;
        ld_sel = '0; ld_data = '0; pair_sel = '0; pair_data = '0; rd_sel = '0;

        vecs[0] = mk(c_op_ld,  3'd0, 16'h0011, 3'd0, 8'h11, 1'b0, 16'h0000);
        vecs[1] = mk(c_op_ld,  3'd1, 16'h00A5, 3'd1, 8'hA5, 1'b0, 16'h0000);
        vecs[2] = mk(c_op_ld,  3'd2, 16'h003C, 3'd2, 8'h3C, 1'b1, 16'h0000);
        vecs[3] = mk(c_op_ld,  3'd3, 16'h005A, 3'd3, 8'h5A, 1'b1, 16'h0000);
        vecs[4] = mk(c_op_pld, 3'd1, 16'h12FF, 3'd6, 8'h12, 1'b1, 16'h12FF);
        vecs[5] = mk(c_op_inc, 3'd1, 16'h0000, 3'd7, 8'h00, 1'b1, 16'h1300);
        vecs[6] = mk(c_op_pld, 3'd0, 16'hFFFF, 3'd5, 8'hFF, 1'b0, 16'hFFFF);
        vecs[7] = mk(c_op_inc, 3'd0, 16'h0000, 3'd4, 8'h00, 1'b0, 16'h0000);
        vecs[8] = mk(c_op_ld,  3'd4, 16'h0077, 3'd4, 8'h77, 1'b0, 16'h7700);
        vecs[9] = mk(c_op_inc, 3'd0, 16'h0000, 3'd5, 8'h01, 1'b0, 16'h7701);
        exp_final = '{8'h11, 8'hA5, 8'h3C, 8'h5A, 8'h77, 8'h01, 8'h13, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            chk("reset_reg", 32'(rd_data), 32'(0));
        end

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            chk("final_reg", 32'(rd_data), 32'(exp_final[i]));
        end
        chk("alu_b", 32'(alu_b), 32'(8'hA5));
        chk("alu_c", 32'(alu_c), 32'(8'h3C));

        // All three requests at once: only the pair load may land.
        @(negedge clk);
        pair_ld_req = 1'b1; inc_req = 1'b1; ld_req = 1'b1;
        pair_sel = 1'b1; pair_data = 16'hBEEF; ld_sel = 3'd0; ld_data = 8'h99;
        @(posedge clk); #1;
        pair_ld_req = 1'b0; inc_req = 1'b0;
`ifdef RELAY_SETTLE_EN
        ld_data = 8'h42;
`else
        ld_req = 1'b0;
`endif
        wait_done(lat, nb);
        ld_req = 1'b0;
        chk("prio_done", 32'(done), 32'(1));
        rd_sel = 3'd0;
        pair_sel = 1'b1;
        #1;
        chk("prio_pair", 32'(pair_rd_data), 32'(16'hBEEF));
        chk("prio_reg0", 32'(rd_data), 32'(8'h11));
        repeat (2) @(posedge clk);
        #1;
        chk("prio_reg0_later", 32'(rd_data), 32'(8'h11));

`ifdef RELAY_SETTLE_EN
        // Old value visible through settle, new value with done.
        @(negedge clk);
        ld_req = 1'b1; ld_sel = 3'd1; ld_data = 8'h5B;
        @(posedge clk); #1;
        ld_req = 1'b0;
        chk("settle_b_old0", 32'(alu_b), 32'(8'hA5));
        chk("settle_busy0", 32'(busy), 32'(1));
        @(posedge clk); #1;
        chk("settle_b_old1", 32'(alu_b), 32'(8'hA5));
        chk("settle_done_early", 32'(done), 32'(0));
        @(posedge clk); #1;
        chk("settle_b_new", 32'(alu_b), 32'(8'h5B));
        chk("settle_done", 32'(done), 32'(1));
        chk("settle_busy_end", 32'(busy), 32'(0));
`else
        // Back-to-back writes commit on every edge.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_req = 1'b1; ld_sel = 3'(i); ld_data = 8'(i + 1); rd_sel = 3'(i);
            @(posedge clk); #1;
            chk("b2b_done", 32'(done), 32'(1));
            chk("b2b_busy", 32'(busy), 32'(0));
            chk("b2b_reg", 32'(rd_data), 32'(i + 1));
        end
        @(negedge clk);
        ld_req = 1'b0;
        @(posedge clk); #1;
        chk("b2b_done_clear", 32'(done), 32'(0));
`endif

        // Asynchronous reset right after accepting a write to reg 3.
        @(negedge clk);
        ld_req = 1'b1; ld_sel = 3'd3; ld_data = 8'h5A; rd_sel = 3'd3;
        @(posedge clk); #2;
        ld_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("areset_busy", 32'(busy), 32'(0));
        chk("areset_done", 32'(done), 32'(0));
        chk("areset_reg3", 32'(rd_data), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1;
        end
        chk("areset_no_done", 32'(seen), 32'(0));
        chk("areset_reg3_later", 32'(rd_data), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
